// File: rtl/ecc32_ram_writer.sv
// ALCT raw-hits buffer write path: accepts a block of 32-bit words, SEC-DED encodes
// each one and writes {parity, data} sequentially into a block-RAM port.

module ecc32_encoder (
  input  logic [31:0] data,
  output logic [6:0]  parity
);
  // Hamming(38,32) check bits over non-power-of-two positions, plus overall parity
  always_comb begin
    int unsigned j;
    parity = '0;
    j      = 0;
    for (int unsigned pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        for (int unsigned k = 0; k < 6; k++) begin
          if (((pos >> k) & 1) != 0) parity[3'(k)] = parity[3'(k)] ^ data[5'(j)];
        end
        j = j + 1;
      end
    end
    parity[6] = ^{data, parity[5:0]};
  end
endmodule

module ecc32_ram_writer #(
  parameter int unsigned ADR_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wr_start,
  input  logic                 wr_end,
  input  logic [31:0]          din,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic                 inj_err,
  output logic                 ram_wen,
  output logic [ADR_WIDTH-1:0] ram_adr,
  output logic [38:0]          ram_wdata,
  output logic                 wr_busy,
  output logic                 wr_full,
  output logic [ADR_WIDTH:0]   wr_nwords,
  output logic                 wr_done
);
  localparam int unsigned NW = ADR_WIDTH + 1;
  localparam logic [ADR_WIDTH:0] DEPTH = {1'b1, {ADR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, WRITE, FLUSH, DONE} state_e;

  state_e                state_q, state_d;
  logic [ADR_WIDTH:0]    nwords_q, nwords_d;
  logic                  full_q, full_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADR_WIDTH-1:0]  wadr_q, wadr_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [31:0]           s1_data_q, s1_data_d;
  logic                  s1_inj_q, s1_inj_d;
  logic                  wen_q, wen_d;
  logic [ADR_WIDTH-1:0]  adr_q, adr_d;
  logic [38:0]           wdata_q, wdata_d;
  logic [6:0]            s1_parity;
  logic                  accept;

  ecc32_encoder u_enc (
    .data   (s1_data_q),
    .parity (s1_parity)
  );

  assign accept = din_valid & ready_q;

  always_comb begin
    state_d    = state_q;
    nwords_d   = nwords_q;
    full_d     = full_q;
    wadr_d     = wadr_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    s1_valid_d = accept;
    s1_data_d  = accept ? din : s1_data_q;
    s1_inj_d   = accept & inj_err;
    wen_d      = s1_valid_q;

    // Stage 2: parity from true data, injected error only on the stored copy
    if (s1_valid_q) begin
      adr_d   = wadr_q;
      wdata_d = {s1_parity, s1_data_q ^ {31'b0, s1_inj_q}};
      wadr_d  = wadr_q + ADR_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (wr_start) begin
          state_d  = WRITE;
          nwords_d = '0;
          full_d   = 1'b0;
          wadr_d   = '0;
        end
      end
      WRITE: begin
        if (accept) begin
          nwords_d = nwords_q + NW'(1);
          if (nwords_d == DEPTH) begin
            full_d  = 1'b1;
            state_d = FLUSH;
          end
        end
        if (wr_end) state_d = FLUSH;
      end
      // Stage 2 still writes on the edge that leaves FLUSH
      FLUSH: if (!s1_valid_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == WRITE) && (nwords_d < DEPTH);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      nwords_q   <= '0;
      full_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wadr_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_inj_q   <= 1'b0;
      wen_q      <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      nwords_q   <= nwords_d;
      full_q     <= full_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wadr_q     <= wadr_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_inj_q   <= s1_inj_d;
      wen_q      <= wen_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign din_ready = ready_q;
  assign ram_wen   = wen_q;
  assign ram_adr   = adr_q;
  assign ram_wdata = wdata_q;
  assign wr_busy   = busy_q;
  assign wr_full   = full_q;
  assign wr_nwords = nwords_q;
  assign wr_done   = done_q;

endmodule

// File: tb/tb_ecc32_ram_writer.sv
// Scoreboard bench for ecc32_ram_writer with a 4-deep buffer: stimulus pushes
// expected RAM writes, a negedge monitor pops and compares them.

module tb_ecc32_ram_writer;
  localparam int unsigned AW = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_start = 1'b0;
  logic          wr_end = 1'b0;
  logic [31:0]   din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic          inj_err = 1'b0;
  logic          ram_wen;
  logic [AW-1:0] ram_adr;
  logic [38:0]   ram_wdata;
  logic          wr_busy;
  logic          wr_full;
  logic [AW:0]   wr_nwords;
  logic          wr_done;

  typedef struct {
    int            cyc;
    logic [AW-1:0] adr;
    logic [38:0]   wdata;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] exp_adr = '0;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  ecc32_ram_writer #(.ADR_WIDTH(AW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_start  (wr_start),
    .wr_end    (wr_end),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .inj_err   (inj_err),
    .ram_wen   (ram_wen),
    .ram_adr   (ram_adr),
    .ram_wdata (ram_wdata),
    .wr_busy   (wr_busy),
    .wr_full   (wr_full),
    .wr_nwords (wr_nwords),
    .wr_done   (wr_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the oldest expectation, including its cycle
  always @(negedge clock) begin
    if (ram_wen) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ram_wen", 64'(ram_adr), 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ram_write{cyc,adr,wdata}", {7'b0, 16'(cyc), 2'(ram_adr), ram_wdata},
              {7'b0, 16'(e.cyc), 2'(e.adr), e.wdata});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_block();
    wr_start = 1'b1;
    exp_adr  = '0;
    tick();
    wr_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic inj, input logic [38:0] exp, input bit push);
    din       = d;
    inj_err   = inj;
    din_valid = 1'b1;
    if (push) begin
      exp_q.push_back('{cyc + 2, exp_adr, exp});
      exp_adr = exp_adr + AW'(1);
    end
    tick();
    din_valid = 1'b0;
    inj_err   = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [AW:0] nwords);
    bit seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (wr_done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
    check({name, "_nwords"}, 64'(wr_nwords), 64'(nwords));
    tick();
    check({name, "_done_pulse_len"}, 64'(wr_done), 64'd0);
    check({name, "_idle_busy"}, 64'(wr_busy), 64'd0);
  endtask

  task automatic end_block(input string name, input logic [AW:0] nwords);
    wr_end = 1'b1;
    tick();
    wr_end = 1'b0;
    wait_done(name, nwords);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("reset_outputs", 64'({ram_wen, ram_adr, ram_wdata, wr_nwords, din_ready,
                                wr_busy, wr_full, wr_done}), 64'd0);
    reset_n = 1'b1;
    tick();
    check("idle_ready", 64'(din_ready), 64'd0);

    // Single word
    start_block();
    check("write_busy", 64'(wr_busy), 64'd1);
    check("write_ready", 64'(din_ready), 64'd1);
    send(32'h0000_0001, 1'b0, 39'h43_0000_0001, 1'b1);
    end_block("single", 3'd1);

    // Parity spot checks
    start_block();
    send(32'h0000_0000, 1'b0, 39'h00_0000_0000, 1'b1);
    send(32'hFFFF_FFFF, 1'b0, 39'h18_FFFF_FFFF, 1'b1);
    send(32'h0000_0001, 1'b0, 39'h43_0000_0001, 1'b1);
    end_block("parity3", 3'd3);

    // Error injection flips stored bit 0 only
    start_block();
    send(32'h0000_0000, 1'b1, 39'h00_0000_0001, 1'b1);
    end_block("inject", 3'd1);

    // Fill to DEPTH with continuous valid, no wr_end
    start_block();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] w;
      logic [38:0] e;
      case (i % 3)
        0:       begin w = 32'h0000_0000; e = 39'h00_0000_0000; end
        1:       begin w = 32'hFFFF_FFFF; e = 39'h18_FFFF_FFFF; end
        default: begin w = 32'h0000_0001; e = 39'h43_0000_0001; end
      endcase
      check($sformatf("fill_ready_%0d", i), 64'(din_ready), 64'(i < 4));
      send(w, 1'b0, e, i < 4);
    end
    check("fill_full", 64'(wr_full), 64'd1);
    wait_done("fill", 3'd4);
    check("fill_full_hold", 64'(wr_full), 64'd1);

    // Handshake gaps and a wr_start ignored during WRITE
    start_block();
    check("restart_full_clear", 64'(wr_full), 64'd0);
    send(32'h0000_0001, 1'b0, 39'h43_0000_0001, 1'b1);
    tick();
    send(32'h0000_0000, 1'b0, 39'h00_0000_0000, 1'b1);
    send(32'hFFFF_FFFF, 1'b0, 39'h18_FFFF_FFFF, 1'b1);
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    check("start_ignored_nwords", 64'(wr_nwords), 64'd3);
    end_block("gaps", 3'd3);

    // Reset one cycle after an accept abandons the block
    start_block();
    send(32'hFFFF_FFFF, 1'b0, 39'h18_FFFF_FFFF, 1'b0);
    reset_n = 1'b0;
    tick();
    check("midreset_outputs", 64'({ram_wen, ram_adr, ram_wdata, wr_nwords, din_ready,
                                   wr_busy, wr_full, wr_done}), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("midreset_idle", 64'(wr_busy), 64'd0);
    start_block();
    send(32'h0000_0001, 1'b0, 39'h43_0000_0001, 1'b1);
    end_block("after_reset", 3'd1);

    repeat (4) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ecc32_ram_writer.md
Name: ecc32_ram_writer

Overview:
- Downstream consumer of the 32-bit/7-parity ECC encoder on the ALCT raw-hits buffer write path.
- Accepts a block of 32-bit words on a valid/ready handshake and registers each accepted word.
- Runs each word through an internal ecc32_encoder instance, then writes the 39-bit {parity, data} word to a sequential block-RAM write port.
- Reports block length and completion to the readout sequencer. The read side, which runs the decoder, is a separate block.

Parameters:
- ADR_WIDTH, 8, RAM address width. Buffer depth DEPTH = 2**ADR_WIDTH words.

Ports:
- clock  input  1  Main logic clock. All logic is on the rising edge.
- reset_n  input  1  Reset, synchronous and active-low. Sampled on the clock edge.
- wr_start  input  1  Opens a new block. Honoured only in IDLE.
- wr_end  input  1  Closes the current block. Honoured only in WRITE.
- din  input  32  Data word.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  Block accepts din this cycle.
- inj_err  input  1  Test only. Inverts stored data bit 0 of the word accepted this cycle; parity is computed from the true data.
- ram_wen  output  1  RAM write enable.
- ram_adr  output  ADR_WIDTH  RAM write address.
- ram_wdata  output  39  Write data: [38:32] = parity, [31:0] = data.
- wr_busy  output  1  State is not IDLE.
- wr_full  output  1  Word count has reached DEPTH.
- wr_nwords  output  ADR_WIDTH+1  Number of words accepted in the current block.
- wr_done  output  1  One-cycle pulse after the last RAM write of a block.

Behaviour:
- Reset (reset_n = 0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including ram_wdata, ram_adr, wr_nwords and din_ready.
  - Pipeline valid bits are cleared, so no ram_wen occurs in the cycle after reset.
  - A block in progress is abandoned; it is not flushed.
- States: IDLE, WRITE, FLUSH, DONE.
- IDLE:
  - din_ready = 0.
  - wr_start = 1 moves to WRITE. The same edge clears wr_nwords, the write address and wr_full.
- WRITE:
  - din_ready = 1 while wr_nwords < DEPTH.
  - accept = din_valid & din_ready.
  - Each accept increments wr_nwords.
  - Transition to FLUSH on either:
    - wr_end = 1. A word accepted in the same cycle is kept.
    - An accept that brings wr_nwords to DEPTH. wr_full asserts on the same edge and din_ready drops the next cycle.
- FLUSH:
  - din_ready = 0.
  - Waits until both pipeline stages are empty (2 cycles at most), then moves to DONE.
- DONE:
  - wr_done = 1 for exactly one cycle, then back to IDLE.
  - wr_nwords and wr_full hold their values until the next wr_start.
- Pipeline, fixed latency of 2 clocks from accept edge to ram_wen:
  - Stage 1 registers din, accept and inj_err.
  - The encoder operates combinationally on the stage-1 data.
  - Stage 2 registers ram_wdata = {parity(s1_data), s1_data ^ {31'b0, s1_inj}}, ram_wen = s1_valid, and ram_adr = the write address.
  - The write address increments after each ram_wen. It never wraps within a block because the DEPTH limit prevents it.
- wr_busy = (state != IDLE).
- Ignored inputs:
  - wr_start outside IDLE, including when it coincides with wr_end.
  - wr_end outside WRITE.
  - din_valid whenever din_ready = 0.
- Back-to-back blocks: wr_start asserted in the cycle after wr_done is honoured.

Test Plan:
- Single word: reset, wr_start, then din = 32'h00000001 with valid, then wr_end → ram_wen 2 clocks after the accept, ram_adr = 0, ram_wdata = 39'h43_00000001, wr_done pulses once, wr_nwords = 1.
- Parity spot checks across a 3-word block with din 32'h0, 32'hFFFFFFFF, 32'h1 → ram_wdata = 39'h00_00000000, 39'h18_FFFFFFFF, 39'h43_00000001 at addresses 0, 1, 2.
- Error injection: din = 0 with inj_err = 1 → ram_wdata = 39'h00_00000001 (parity unchanged, data bit 0 flipped).
- Fill (ADR_WIDTH = 2, DEPTH = 4): continuous valid for 6 cycles → exactly 4 accepts, wr_full = 1, din_ready low from cycle 5, addresses 0..3 written, wr_done without any wr_end, wr_nwords = 4.
- Handshake gaps: din_valid toggling 1,0,1,1 → wr_nwords = 3 and contiguous addresses 0..2; wr_start during WRITE is ignored (wr_nwords is not cleared).
- Reset mid-block: reset_n = 0 one cycle after an accept → no ram_wen, all outputs 0, state IDLE; a new block after reset starts at address 0.
